aoi221_arc_tester: RTL and testbench
====================================

Name: aoi221_arc_tester

Overview:
- Sequential self-test stage that drives the five inputs of an AOI221 cell instance (A, B1, B2, C1, C2) and consumes its ZN output.
- Walks all 21 sensitized conditional timing arcs of the cell. For each arc it holds the side inputs, drives the switching pin low then high, and checks ZN against the expected value.
- Used on silicon/characterization test structures and in gate-level regression to confirm that every arc is functionally sensitizable.

Parameters:
- SETTLE_CYC, 2, cycles ZN is allowed to settle after each input change before it is sampled; legal range 1..15.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  begins a full sweep; sampled only in IDLE or DONE.
- zn  input  1  ZN output of the cell under test.
- a_o  output  1  drives A.
- b1_o  output  1  drives B1.
- b2_o  output  1  drives B2.
- c1_o  output  1  drives C1.
- c2_o  output  1  drives C2.
- busy  output  1  high in DRIVE/WAIT/CHECK.
- done  output  1  high in DONE; sticky until next start or reset.
- err_cnt  output  6  number of failed checks (max 42).
- fail_valid  output  1  at least one check has failed.
- fail_id  output  6  first failing check, formatted {arc[4:0], ph}.

Behaviour:
- Reset: async clears everything. State=IDLE; all pin outputs 0; busy, done, err_cnt, fail_valid and fail_id all 0. Reset asserted mid-sweep aborts the sweep immediately; no partial result is retained.
- Arc table, index: switching pin, then side values:
  - 0-8: pin A; (B1,B2,C1,C2) = 0000, 0001, 0010, 0100, 0101, 0110, 1000, 1001, 1010.
  - 9-11: pin B1; A=0, B2=1, (C1,C2) = 00, 01, 10.
  - 12-14: pin B2; A=0, B1=1, (C1,C2) = 00, 01, 10.
  - 15-17: pin C1; A=0, C2=1, (B1,B2) = 00, 01, 10.
  - 18-20: pin C2; A=0, C1=1, (B1,B2) = 00, 01, 10.
- Phase ph: 0 drives the switching pin low, with expected zn=1. 1 drives it high, with expected zn=0.
- FSM states: IDLE, DRIVE, WAIT, CHECK, DONE.
  - IDLE/DONE with start=1: clear err_cnt, fail_valid, fail_id and done; set arc=0, ph=0; go to DRIVE.
  - DRIVE (1 cycle): register all five pin outputs from table[arc] and ph. Load settle counter with SETTLE_CYC-1. Go to WAIT.
  - WAIT: stays exactly SETTLE_CYC cycles, then goes to CHECK.
  - CHECK (1 cycle), mismatch handling: if zn != ~ph, increment err_cnt (saturating at 63). If fail_valid=0, also set fail_valid and fail_id={arc,ph}.
  - CHECK, next step: if ph=0, set ph=1 and go to DRIVE. Else if arc=20, go to DONE. Else arc++, ph=0, go to DRIVE.
  - DONE: done=1, busy=0; pin outputs keep the last vector.
- start while busy is ignored.
- Timing: 42 checks, each taking 2+SETTLE_CYC cycles. done rises 42*(2+SETTLE_CYC) edges after the start-sampling edge, i.e. 168 with the default.
- zn is sampled only in CHECK; it is not synchronized internally.

Optional Feature:
- Macro AOI221_ARC_LOG_EN.
- Defined: adds output fail_map[20:0]. Bit i is set when either check of arc i fails. It is cleared on start and on reset.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package aoi221_arc_pkg contains:
  - NUM_ARCS=21.
  - Pin enum PIN_A, PIN_B1, PIN_B2, PIN_C1, PIN_C2.
  - arc_t struct {pin, side[4:0]}.
  - The state enum.
- Sub-module aoi221_arc_rom: combinational arc index -> arc_t lookup, plus expansion with ph into the five pin values.

Test Plan:
- Golden AOI221 model on zn, pulse start -> busy for 168 cycles, done=1 at edge 168, err_cnt=0, fail_valid=0.
- zn tied 1 -> err_cnt=21, fail_id={0,1}=6'd1, done at 168.
- zn = ~(golden ZN) -> err_cnt=42, fail_id=6'd0.
- Model with C1 stuck-at-0 -> err_cnt=6 (arcs 15-20, ph=1), fail_id={15,1}=6'd31; with AOI221_ARC_LOG_EN, fail_map=21'h1F8000.
- RST pulsed at cycle 50 of a sweep -> all outputs 0 asynchronously. New start -> clean golden sweep, err_cnt=0.
- start re-pulsed at cycle 20 while busy -> ignored; done still at edge 168. SETTLE_CYC=1 build -> done at edge 126.

Source files
------------

// File: rtl/aoi221_arc_tester_pkg.sv
// Shared types for the AOI221 timing-arc self-test stage.
// Arc encoding, pin identifiers and FSM states.
package aoi221_arc_pkg;

    localparam int NUM_ARCS = 21;
    localparam logic [4:0] LAST_ARC = 5'(NUM_ARCS - 1);

    // Switching pin of an arc; side[] order is {A, B1, B2, C1, C2}
    typedef enum logic [2:0] {
        PIN_A,
        PIN_B1,
        PIN_B2,
        PIN_C1,
        PIN_C2
    } pin_e;

    typedef struct packed {
        pin_e       pin;
        logic [4:0] side;
    } arc_t;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CHECK,
        DONE
    } state_e;

    // Low phase must leave the output high, high phase must pull it low
    function automatic logic exp_zn(input logic ph);
        return ~ph;
    endfunction

endpackage

// File: rtl/aoi221_arc_tester_if.sv
// Control/observe bundle between the arc tester and its environment.
// AOI221_ARC_LOG_EN adds the per-arc fail_map vector.
interface aoi221_arc_tester_if;
    import aoi221_arc_pkg::*;

    logic       start;
    logic       zn;
    logic       a_o;
    logic       b1_o;
    logic       b2_o;
    logic       c1_o;
    logic       c2_o;
    logic       busy;
    logic       done;
    logic [5:0] err_cnt;
    logic       fail_valid;
    logic [5:0] fail_id;
`ifdef AOI221_ARC_LOG_EN
    logic [NUM_ARCS-1:0] fail_map;

    modport master (
        input  start, zn,
        output a_o, b1_o, b2_o, c1_o, c2_o,
        output busy, done, err_cnt, fail_valid, fail_id, fail_map
    );

    modport slave (
        output start, zn,
        input  a_o, b1_o, b2_o, c1_o, c2_o,
        input  busy, done, err_cnt, fail_valid, fail_id, fail_map
    );
`else
    modport master (
        input  start, zn,
        output a_o, b1_o, b2_o, c1_o, c2_o,
        output busy, done, err_cnt, fail_valid, fail_id
    );

    modport slave (
        output start, zn,
        input  a_o, b1_o, b2_o, c1_o, c2_o,
        input  busy, done, err_cnt, fail_valid, fail_id
    );
`endif

endinterface

// File: rtl/aoi221_arc_tester_rom.sv
// Arc table lookup: arc index -> switching pin and side values,
// expanded with the phase into the five pin drive values.
module aoi221_arc_rom
    import aoi221_arc_pkg::*;
(
    input  logic [4:0] arc,
    input  logic       ph,
    output logic [4:0] pins
);

    arc_t entry;

    // Sensitizing side values per arc, order {A, B1, B2, C1, C2}
    always_comb begin
        entry = '{pin: PIN_A, side: 5'b00000};
        case (arc)
            5'd0:  entry = '{pin: PIN_A,  side: 5'b00000};
            5'd1:  entry = '{pin: PIN_A,  side: 5'b00001};
            5'd2:  entry = '{pin: PIN_A,  side: 5'b00010};
            5'd3:  entry = '{pin: PIN_A,  side: 5'b00100};
            5'd4:  entry = '{pin: PIN_A,  side: 5'b00101};
            5'd5:  entry = '{pin: PIN_A,  side: 5'b00110};
            5'd6:  entry = '{pin: PIN_A,  side: 5'b01000};
            5'd7:  entry = '{pin: PIN_A,  side: 5'b01001};
            5'd8:  entry = '{pin: PIN_A,  side: 5'b01010};
            5'd9:  entry = '{pin: PIN_B1, side: 5'b00100};
            5'd10: entry = '{pin: PIN_B1, side: 5'b00101};
            5'd11: entry = '{pin: PIN_B1, side: 5'b00110};
            5'd12: entry = '{pin: PIN_B2, side: 5'b01000};
            5'd13: entry = '{pin: PIN_B2, side: 5'b01001};
            5'd14: entry = '{pin: PIN_B2, side: 5'b01010};
            5'd15: entry = '{pin: PIN_C1, side: 5'b00001};
            5'd16: entry = '{pin: PIN_C1, side: 5'b00101};
            5'd17: entry = '{pin: PIN_C1, side: 5'b01001};
            5'd18: entry = '{pin: PIN_C2, side: 5'b00010};
            5'd19: entry = '{pin: PIN_C2, side: 5'b00110};
            5'd20: entry = '{pin: PIN_C2, side: 5'b01010};
            default: entry = '{pin: PIN_A, side: 5'b00000};
        endcase
    end

    // Overlay the phase onto the switching pin's slot
    always_comb begin
        pins = entry.side;
        case (entry.pin)
            PIN_A:   pins[4] = ph;
            PIN_B1:  pins[3] = ph;
            PIN_B2:  pins[2] = ph;
            PIN_C1:  pins[1] = ph;
            PIN_C2:  pins[0] = ph;
            default: pins[4] = ph;
        endcase
    end

endmodule

// File: rtl/aoi221_arc_tester.sv
// AOI221 arc tester: sweeps 21 arcs x 2 phases, checks zn after settling.
// Optional AOI221_ARC_LOG_EN adds fail_map (one bit per failing arc).
module aoi221_arc_tester
    import aoi221_arc_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input logic CK,
    input logic RST,
    aoi221_arc_tester_if.master bus
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);

    state_e     state;
    state_e     state_nxt;
    logic [4:0] arc;
    logic       ph;
    logic [3:0] cnt;
    logic [4:0] rom_pins;
    logic [4:0] pins_q;
    logic [5:0] err_q;
    logic       fv_q;
    logic [5:0] fid_q;
    logic       mismatch;
`ifdef AOI221_ARC_LOG_EN
    logic [NUM_ARCS-1:0] map_q;
`endif

    aoi221_arc_rom u_rom (
        .arc  (arc),
        .ph   (ph),
        .pins (rom_pins)
    );

    assign mismatch = (state == CHECK) && (bus.zn != exp_zn(ph));

    // State register
    always_ff @(posedge CK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: drive, settle, check, step to next phase/arc
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.start) state_nxt = DRIVE;
            DRIVE:      state_nxt = WAIT;
            WAIT:       if (cnt == 4'd0) state_nxt = CHECK;
            CHECK: begin
                if (!ph)                  state_nxt = DRIVE;
                else if (arc == LAST_ARC) state_nxt = DONE;
                else                      state_nxt = DRIVE;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    // Sweep position, pin drive, settle counter and result capture
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            arc    <= '0;
            ph     <= 1'b0;
            cnt    <= '0;
            pins_q <= '0;
            err_q  <= '0;
            fv_q   <= 1'b0;
            fid_q  <= '0;
`ifdef AOI221_ARC_LOG_EN
            map_q  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        arc   <= '0;
                        ph    <= 1'b0;
                        err_q <= '0;
                        fv_q  <= 1'b0;
                        fid_q <= '0;
`ifdef AOI221_ARC_LOG_EN
                        map_q <= '0;
`endif
                    end
                end
                DRIVE: begin
                    pins_q <= rom_pins;
                    cnt    <= SETTLE_LD;
                end
                WAIT: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_q != 6'd63) err_q <= err_q + 6'd1;
                        if (!fv_q) begin
                            fv_q  <= 1'b1;
                            fid_q <= {arc, ph};
                        end
`ifdef AOI221_ARC_LOG_EN
                        map_q[arc] <= 1'b1;
`endif
                    end
                    if (!ph) begin
                        ph <= 1'b1;
                    end else if (arc != LAST_ARC) begin
                        arc <= arc + 5'd1;
                        ph  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign {bus.a_o, bus.b1_o, bus.b2_o, bus.c1_o, bus.c2_o} = pins_q;
    assign bus.busy       = (state == DRIVE) || (state == WAIT) || (state == CHECK);
    assign bus.done       = (state == DONE);
    assign bus.err_cnt    = err_q;
    assign bus.fail_valid = fv_q;
    assign bus.fail_id    = fid_q;
`ifdef AOI221_ARC_LOG_EN
    assign bus.fail_map   = map_q;
`endif

endmodule

// File: tb/tb_aoi221_arc_tester.sv
// Directed bench for aoi221_arc_tester with a behavioural AOI221 model.
// Covers golden, stuck/inverted faults, reset abort, restart, SETTLE_CYC=1.
module tb_aoi221_arc_tester;

    logic CK = 1'b0;
    logic RST;
    int   mode;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 CK = ~CK;

    aoi221_arc_tester_if bus ();
    aoi221_arc_tester_if bus1 ();

    // 0 golden, 1 zn tied high, 2 inverted, 3 C1 stuck-at-0
    function automatic logic zn_model(input int m, input logic a, input logic b1,
                                      input logic b2, input logic c1, input logic c2);
        logic g;
        g = ~(a | (b1 & b2) | (c1 & c2));
        case (m)
            1:       return 1'b1;
            2:       return ~g;
            3:       return ~(a | (b1 & b2));
            default: return g;
        endcase
    endfunction

    assign bus.zn  = zn_model(mode, bus.a_o, bus.b1_o, bus.b2_o, bus.c1_o, bus.c2_o);
    assign bus1.zn = zn_model(0, bus1.a_o, bus1.b1_o, bus1.b2_o, bus1.c1_o, bus1.c2_o);

    aoi221_arc_tester #(.SETTLE_CYC(2)) u_dut (
        .CK  (CK),
        .RST (RST),
        .bus (bus.master)
    );

    aoi221_arc_tester #(.SETTLE_CYC(1)) u_dut1 (
        .CK  (CK),
        .RST (RST),
        .bus (bus1.master)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] pins();
        return {bus.a_o, bus.b1_o, bus.b2_o, bus.c1_o, bus.c2_o};
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_pins"}, 32'(pins()), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_err"}, 32'(bus.err_cnt), 0);
        chk({tag, "_fv"}, 32'(bus.fail_valid), 0);
        chk({tag, "_fid"}, 32'(bus.fail_id), 0);
`ifdef AOI221_ARC_LOG_EN
        chk({tag, "_map"}, 32'(bus.fail_map), 0);
`endif
    endtask

    // One sweep on the SETTLE_CYC=2 instance; optional restart or reset pulse
    task automatic sweep(input int m, input int restart_at, input int rst_at);
        int cyc;
        mode = m;
        @(negedge CK) bus.start = 1'b1;
        @(posedge CK);
        #1 bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 1);
        cyc = 0;
        while (cyc < 400) begin
            @(posedge CK);
            cyc++;
            #1;
            if (cyc == rst_at) begin
                RST = 1'b1;
                #1 chk_idle("rst_mid");
                @(negedge CK) RST = 1'b0;
                return;
            end
            if (cyc == restart_at)     bus.start = 1'b1;
            if (cyc == restart_at + 1) bus.start = 1'b0;
            if (cyc == 1)   chk("pins_arc0_ph0", 32'(pins()), 32'b00000);
            if (cyc == 5)   chk("pins_arc0_ph1", 32'(pins()), 32'b10000);
            if (cyc == 73)  chk("pins_arc9_ph0", 32'(pins()), 32'b00100);
            if (cyc == 100) chk("busy_mid", 32'(bus.busy), 1);
            if (bus.done) break;
        end
        chk("done_edge", 32'(cyc), 168);
        chk("busy_at_done", 32'(bus.busy), 0);
        chk("pins_last", 32'(pins()), 32'b01011);
    endtask

    initial begin
        int cyc;
        RST = 1'b1;
        mode = 0;
        bus.start = 1'b0;
        bus1.start = 1'b0;
        repeat (3) @(posedge CK);
        #1 chk_idle("reset");
        @(negedge CK) RST = 1'b0;

        sweep(0, -10, -1);
        chk("gold_err", 32'(bus.err_cnt), 0);
        chk("gold_fv", 32'(bus.fail_valid), 0);
        chk("gold_fid", 32'(bus.fail_id), 0);
        repeat (3) @(posedge CK);
        #1 chk("done_sticky", 32'(bus.done), 1);

        sweep(1, -10, -1);
        chk("tied1_err", 32'(bus.err_cnt), 21);
        chk("tied1_fv", 32'(bus.fail_valid), 1);
        chk("tied1_fid", 32'(bus.fail_id), 1);

        sweep(2, -10, -1);
        chk("inv_err", 32'(bus.err_cnt), 42);
        chk("inv_fid", 32'(bus.fail_id), 0);

        sweep(3, -10, -1);
        chk("c1sa0_err", 32'(bus.err_cnt), 6);
        chk("c1sa0_fid", 32'(bus.fail_id), 31);
`ifdef AOI221_ARC_LOG_EN
        chk("c1sa0_map", 32'(bus.fail_map), 32'h1F8000);
`endif

        sweep(3, -10, 50);
        sweep(0, -10, -1);
        chk("post_rst_err", 32'(bus.err_cnt), 0);
        chk("post_rst_fv", 32'(bus.fail_valid), 0);

        sweep(0, 20, -1);
        chk("restart_err", 32'(bus.err_cnt), 0);

        @(negedge CK) bus1.start = 1'b1;
        @(posedge CK);
        #1 bus1.start = 1'b0;
        cyc = 0;
        while (cyc < 400) begin
            @(posedge CK);
            cyc++;
            #1;
            if (bus1.done) break;
        end
        chk("s1_done_edge", 32'(cyc), 126);
        chk("s1_err", 32'(bus1.err_cnt), 0);
        chk("s1_fv", 32'(bus1.fail_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
